wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//   Writeback stage plus architectural register file. Consumes the writeback control signals registered
//   by the writeback-stage control register, selects the writeback value, and commits it to a
//   32 x XLEN register file. Provides two combinational read ports for the decode stage, the selected
//   writeback value for forwarding, and a wrapping count of committed writes.
// PARAMETERS
//   XLEN     32  datapath width
//   REG_NUM  32  number of architectural registers (register 0 hardwired to zero)
//   AW       5   register address width, clog2(REG_NUM)
//   CNT_W    32  width of committed-write counter
// PORTS
//   clk         in   1      clock, rising edge
//   rst         in   1      reset: synchronous, active-high
//   enable      in   1      writeback stage enable; 0 = stall, no commit
//   mem_to_reg  in   1      select mem_rdata as writeback value
//   pc_to_reg   in   1      select pc_plus4 as writeback value (JAL/JALR link)
//   reg_write   in   1      commit request for this cycle
//   rd_addr     in   AW     destination register
//   alu_result  in   XLEN   ALU result from the memory-stage datapath register
//   mem_rdata   in   XLEN   load data from data memory
//   pc_plus4    in   XLEN   return address
//   rs1_addr    in   AW     read port 1 address
//   rs2_addr    in   AW     read port 2 address
//   rs1_data    out  XLEN   read port 1 data, combinational
//   rs2_data    out  XLEN   read port 2 data, combinational
//   wb_data     out  XLEN   selected writeback value, combinational (forwarding source)
//   wb_commit   out  1      enable & reg_write & (rd_addr != 0) & !rst, combinational
//   wr_count    out  CNT_W  number of committed writes, registered
// BEHAVIOUR
//   - Select priority: pc_to_reg > mem_to_reg > alu_result. Both selects high -> pc_plus4.
//   - Commit: on posedge clk, if wb_commit is high, regs[rd_addr] <= wb_data. Latency 1 cycle.
//   - Writes to register 0 are dropped. Register 0 reads 0 on both ports. No commit, no count.
//   - enable = 0: register array and wr_count hold. wb_data still reflects the inputs.
//   - Reset: synchronous, active-high. On posedge clk with rst = 1, all REG_NUM registers <= 0 and
//     wr_count <= 0. rst overrides a simultaneous commit. After reset, rs1_data/rs2_data = 0 for every
//     address and wr_count = 0. Initial contents before the first reset are undefined.
//   - wr_count increments by 1 per committed write and wraps from 2^CNT_W-1 to 0.
//   - Both read ports may address the same register; each returns the same value.
//   - Same-cycle read/write to the same nonzero register: behaviour is set by WB_BYPASS_EN
//     (see CONFIGURATION).
// CONFIGURATION
//   WB_BYPASS_EN defined: write-through. If wb_commit is high and rsN_addr == rd_addr != 0, rsN_data
//     returns wb_data in the same cycle. This removes the WB->ID forwarding path from the hazard unit.
//   WB_BYPASS_EN undefined: rsN_data returns the pre-write array value. The new value is visible from
//     the next cycle. The hazard/forwarding unit must cover this case.
// STRUCTURE
//   - Shared package/header (cpu_defs): XLEN, AW, REG_NUM, REG_ZERO = 0.
//   - Sub-module wb_mux: combinational 3:1 priority select (pc_to_reg, mem_to_reg, alu_result -> wb_data).
//   - Register array, commit logic, bypass and counter stay in wb_regfile.
// TESTING
//   1. rst = 1 for 1 cycle, then read all 32 addresses -> all 0. wr_count = 0.
//   2. reg_write = 1, rd = 5, alu_result = 0x1234, both selects 0 -> next cycle rs1(5) = 0x1234, wr_count = 1.
//   3. mem_to_reg = 1, pc_to_reg = 1, pc_plus4 = 0x40, mem_rdata = 0xAA, rd = 3
//      -> wb_data = 0x40, regs[3] = 0x40.
//   4. rd = 0, reg_write = 1, alu_result = 0xFFFF -> wb_commit = 0, rs1(0) = 0, wr_count unchanged.
//   5. enable = 0 with reg_write = 1, rd = 7 -> regs[7] unchanged. Then assert rst and reg_write together
//      -> regs[7] = 0, wr_count = 0.
//   6. Write rd = 9 = 0x55 while rs2 = 9 (old value 0x11) -> rs2_data = 0x55 with WB_BYPASS_EN,
//      0x11 without. Both builds read 0x55 next cycle.
//   7. Preload wr_count to 2^CNT_W - 1 (or use a CNT_W = 4 build) and commit -> wr_count wraps to 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared CPU definitions for the writeback stage and register file.
// Optional feature macro used by the register file: WB_BYPASS_EN.
package wb_regfile_pkg;

   localparam int XLEN     = 32;
   localparam int REG_NUM  = 32;
   localparam int AW       = $clog2(REG_NUM);
   localparam int CNT_W    = 32;
   localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_regfile_wb_mux.sv
// Writeback value select: pc_plus4 beats mem_rdata beats alu_result.
module wb_mux #(
   parameter int XLEN = wb_regfile_pkg::XLEN
) (
   input  logic            mem_to_reg,
   input  logic            pc_to_reg,
   input  logic [XLEN-1:0] alu_result,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic [XLEN-1:0] pc_plus4,
   output logic [XLEN-1:0] wb_data
);

   // Priority select of the writeback value.
   always_comb begin
      // NOTE: the default assignment first means every path drives wb_data, so no latch is inferred.
      wb_data = alu_result;
      if (pc_to_reg) begin
         wb_data = pc_plus4;
      end else if (mem_to_reg) begin
         wb_data = mem_rdata;
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus architectural register file with two combinational
// read ports and a wrapping committed-write counter.
// Optional feature macro: WB_BYPASS_EN (write-through on same-cycle read/write).
module wb_regfile #(
   parameter int XLEN    = wb_regfile_pkg::XLEN,
   parameter int REG_NUM = wb_regfile_pkg::REG_NUM,
   parameter int AW      = wb_regfile_pkg::AW,
   parameter int CNT_W   = wb_regfile_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             mem_to_reg,
   input  logic             pc_to_reg,
   input  logic             reg_write,
   input  logic [AW-1:0]    rd_addr,
   input  logic [XLEN-1:0]  alu_result,
   input  logic [XLEN-1:0]  mem_rdata,
   input  logic [XLEN-1:0]  pc_plus4,
   input  logic [AW-1:0]    rs1_addr,
   input  logic [AW-1:0]    rs2_addr,
   output logic [XLEN-1:0]  rs1_data,
   output logic [XLEN-1:0]  rs2_data,
   output logic [XLEN-1:0]  wb_data,
   output logic             wb_commit,
   output logic [CNT_W-1:0] wr_count
);

   import wb_regfile_pkg::*;

   localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

   logic [XLEN-1:0] regs [REG_NUM];

   wb_mux #(.XLEN(XLEN)) u_wb_mux (
      .mem_to_reg (mem_to_reg),
      .pc_to_reg  (pc_to_reg),
      .alu_result (alu_result),
      .mem_rdata  (mem_rdata),
      .pc_plus4   (pc_plus4),
      .wb_data    (wb_data)
   );

   // A commit needs the stage enabled, a write request, a nonzero target and no reset.
   assign wb_commit = enable & reg_write & (rd_addr != ZERO_ADDR) & ~rst;

   // Register array: cleared by reset, written on commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the array is reset because software relies on all registers reading 0 after reset;
         // this keeps it in flops rather than a RAM macro.
         for (int i = 0; i < REG_NUM; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_commit) begin
         // NOTE: state is updated with <= so every read in this cycle sees the pre-edge value.
         regs[rd_addr] <= wb_data;
      end
   end

   // Committed-write counter; wraps naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_count <= '0;
      end else if (wb_commit) begin
         wr_count <= wr_count + CNT_W'(1);
      end
   end

   // Read ports: register 0 reads zero; optional write-through of the value being committed.
   always_comb begin
      rs1_data = (rs1_addr == ZERO_ADDR) ? '0 : regs[rs1_addr];
      rs2_data = (rs2_addr == ZERO_ADDR) ? '0 : regs[rs2_addr];
`ifdef WB_BYPASS_EN
      if (wb_commit && (rs1_addr == rd_addr)) begin
         rs1_data = wb_data;
      end
      if (wb_commit && (rs2_addr == rd_addr)) begin
         rs2_data = wb_data;
      end
`else
      // Without write-through the new value appears from the next cycle; forwarding covers the gap.
`endif
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile. A second instance with a
// 4-bit counter shares the inputs and exercises counter wrap.
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        mem_to_reg;
   logic        pc_to_reg;
   logic        reg_write;
   logic [4:0]  rd_addr;
   logic [31:0] alu_result;
   logic [31:0] mem_rdata;
   logic [31:0] pc_plus4;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] wb_data;
   logic        wb_commit;
   logic [31:0] wr_count;

   logic [31:0] rs1_data4;
   logic [31:0] rs2_data4;
   logic [31:0] wb_data4;
   logic        wb_commit4;
   logic [3:0]  wr_count4;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_cnt  = 0;

   wb_regfile dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .mem_to_reg (mem_to_reg),
      .pc_to_reg  (pc_to_reg),
      .reg_write  (reg_write),
      .rd_addr    (rd_addr),
      .alu_result (alu_result),
      .mem_rdata  (mem_rdata),
      .pc_plus4   (pc_plus4),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .wb_data    (wb_data),
      .wb_commit  (wb_commit),
      .wr_count   (wr_count)
   );

   wb_regfile #(.CNT_W(4)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .mem_to_reg (mem_to_reg),
      .pc_to_reg  (pc_to_reg),
      .reg_write  (reg_write),
      .rd_addr    (rd_addr),
      .alu_result (alu_result),
      .mem_rdata  (mem_rdata),
      .pc_plus4   (pc_plus4),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .rs1_data   (rs1_data4),
      .rs2_data   (rs2_data4),
      .wb_data    (wb_data4),
      .wb_commit  (wb_commit4),
      .wr_count   (wr_count4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed === expected) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Commit an ALU value to rd through one clock edge, then drop the request.
   task automatic write_alu(input logic [4:0] rd, input logic [31:0] val);
      enable     = 1'b1;
      mem_to_reg = 1'b0;
      pc_to_reg  = 1'b0;
      reg_write  = 1'b1;
      rd_addr    = rd;
      alu_result = val;
      @(negedge clk);
      reg_write  = 1'b0;
      if (rd != 5'd0) exp_cnt++;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; mem_to_reg = 1'b0; pc_to_reg = 1'b0; reg_write = 1'b0;
      rd_addr = '0; alu_result = '0; mem_rdata = '0; pc_plus4 = '0; rs1_addr = '0; rs2_addr = '0;

      // 1: reset for one cycle, all registers read zero
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'(31 - i);
         #1;
         check($sformatf("reset_rs1[%0d]", i), rs1_data, 32'h0);
         check($sformatf("reset_rs2[%0d]", 31 - i), rs2_data, 32'h0);
      end
      check("reset_wr_count", wr_count, 32'd0);
      check("reset_wr_count4", 32'(wr_count4), 32'd0);
      @(negedge clk);

      // 2: ALU writeback to x5
      rd_addr = 5'd5; alu_result = 32'h1234; reg_write = 1'b1;
      #1;
      check("alu_wb_data", wb_data, 32'h1234);
      check("alu_wb_commit", 32'(wb_commit), 32'd1);
      @(negedge clk);
      reg_write = 1'b0; exp_cnt++;
      rs1_addr = 5'd5; rs2_addr = 5'd5;
      #1;
      check("x5_rs1", rs1_data, 32'h1234);
      check("x5_rs2_same", rs2_data, 32'h1234);
      check("count_after_x5", wr_count, 32'(exp_cnt));

      // 3: both selects high -> pc_plus4 wins
      mem_to_reg = 1'b1; pc_to_reg = 1'b1; pc_plus4 = 32'h40; mem_rdata = 32'hAA;
      alu_result = 32'h777; rd_addr = 5'd3; reg_write = 1'b1;
      #1;
      check("sel_both_wb_data", wb_data, 32'h40);
      @(negedge clk);
      reg_write = 1'b0; exp_cnt++;
      pc_to_reg = 1'b0;
      rs2_addr = 5'd3;
      #1;
      check("sel_mem_wb_data", wb_data, 32'hAA);
      check("x3_rs2", rs2_data, 32'h40);
      check("count_after_x3", wr_count, 32'(exp_cnt));
      mem_to_reg = 1'b0;
      #1;
      check("sel_alu_wb_data", wb_data, 32'h777);

      // 4: writes to x0 are dropped
      @(negedge clk);
      rd_addr = 5'd0; alu_result = 32'hFFFF; reg_write = 1'b1;
      #1;
      check("x0_wb_commit", 32'(wb_commit), 32'd0);
      @(negedge clk);
      reg_write = 1'b0;
      rs1_addr = 5'd0;
      #1;
      check("x0_rs1", rs1_data, 32'h0);
      check("count_after_x0", wr_count, 32'(exp_cnt));

      // 5: stall holds state, then reset beats a simultaneous commit
      write_alu(5'd7, 32'h77);
      enable = 1'b0; reg_write = 1'b1; rd_addr = 5'd7; alu_result = 32'h99;
      #1;
      check("stall_wb_commit", 32'(wb_commit), 32'd0);
      check("stall_wb_data", wb_data, 32'h99);
      @(negedge clk);
      rs1_addr = 5'd7;
      #1;
      check("stall_x7_hold", rs1_data, 32'h77);
      check("stall_count_hold", wr_count, 32'(exp_cnt));
      enable = 1'b1; rst = 1'b1;
      #1;
      check("rst_wb_commit", 32'(wb_commit), 32'd0);
      @(negedge clk);
      rst = 1'b0; reg_write = 1'b0; exp_cnt = 0;
      rs2_addr = 5'd5;
      #1;
      check("rst_x7", rs1_data, 32'h0);
      check("rst_x5", rs2_data, 32'h0);
      check("rst_count", wr_count, 32'd0);

      // 6: same-cycle read of the register being written
      write_alu(5'd9, 32'h11);
      rs1_addr = 5'd9; rs2_addr = 5'd9;
      rd_addr = 5'd9; alu_result = 32'h55; reg_write = 1'b1;
      #1;
`ifdef WB_BYPASS_EN
      check("same_cycle_rs2", rs2_data, 32'h55);
      check("same_cycle_rs1", rs1_data, 32'h55);
`else
      check("same_cycle_rs2", rs2_data, 32'h11);
      check("same_cycle_rs1", rs1_data, 32'h11);
`endif
      @(negedge clk);
      reg_write = 1'b0; exp_cnt++;
      #1;
      check("next_cycle_rs2", rs2_data, 32'h55);
      check("count_after_x9", wr_count, 32'(exp_cnt));

      // 7: 4-bit counter wraps from 15 to 0
      for (int k = 0; k < 13; k++) begin
         write_alu(5'(10 + k), 32'(k + 100));
      end
      rs1_addr = 5'd22;
      #1;
      check("x22_value", rs1_data, 32'd112);
      check("count4_at_15", 32'(wr_count4), 32'd15);
      check("count_at_15", wr_count, 32'(exp_cnt));
      write_alu(5'd23, 32'hBEEF);
      #1;
      check("count4_wrap", 32'(wr_count4), 32'd0);
      check("count_at_16", wr_count, 32'(exp_cnt));
      check("count_is_16", wr_count, 32'd16);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
